// File: rtl/y86_pkg.sv
// y86_pkg: shared definitions for the Y86-64 fetch stage.
//   - Instruction codes I_HALT .. I_POPQ (upper nibble of the first byte).
//   - Status codes S_AOK / S_HLT / S_ADR / S_INS reported with each packet.
//   - REG_NONE, the register id used when an instruction has no register byte.
//   - fetchState_t, the fetch status FSM encoding.
//   - instrLen(), instruction length in bytes from icode.
//   - isValidIcode(), true for icodes the ISA defines.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_CMOVXX = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [2:0] S_AOK = 3'd1;
   localparam logic [2:0] S_HLT = 3'd2;
   localparam logic [2:0] S_ADR = 3'd3;
   localparam logic [2:0] S_INS = 3'd4;

   localparam logic [3:0] REG_NONE = 4'hF;

   typedef enum logic [1:0] {
      ST_RUN = 2'd0,
      ST_HLT = 2'd1,
      ST_ERR = 2'd2
   } fetchState_t;

   // Instruction length in bytes. Unknown icodes count as one byte so the
   // faulting packet still gets a sensible valP.
   function automatic logic [3:0] instrLen(input logic [3:0] icode);
      case (icode)
         I_HALT, I_NOP, I_RET:               instrLen = 4'd1;
         I_CMOVXX, I_OPQ, I_PUSHQ, I_POPQ:   instrLen = 4'd2;
         I_JXX, I_CALL:                      instrLen = 4'd9;
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:       instrLen = 4'd10;
         default:                            instrLen = 4'd1;
      endcase
   endfunction

   function automatic logic isValidIcode(input logic [3:0] icode);
      isValidIcode = (icode <= I_POPQ);
   endfunction

endpackage

// File: rtl/y86_imem.sv
// y86_imem: byte-addressed instruction memory.
//   Ports:
//     clk    in   clock for the loader write port
//     we     in   byte write enable
//     waddr  in   byte write address
//     wdata  in   byte to write
//     raddr  in   64-bit byte address of the read window
//     rdata  out  FETCH_W bytes starting at raddr, little-endian
//                 (byte raddr in rdata[7:0]); bytes past the end read 0
//   Writes land on the clock edge, so a read of the byte being written in
//   the same cycle returns the old contents.
module y86_imem #(
   parameter int IMEM_BYTES = 1024,
   parameter int FETCH_W    = 10
)(
   input  logic                          clk,
   input  logic                          we,
   input  logic [$clog2(IMEM_BYTES)-1:0] waddr,
   input  logic [7:0]                    wdata,
   input  logic [63:0]                   raddr,
   output logic [8*FETCH_W-1:0]          rdata
);

   localparam int AW = $clog2(IMEM_BYTES);

   logic [7:0] r_mem [IMEM_BYTES];

   // Loader port. No reset: program contents survive a fetch-unit reset.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   // Read window. The byte address is widened to 65 bits so a window that
   // starts near the top of the 64-bit space does not wrap back into memory.
   always_comb begin
      logic [64:0] addrK;
      rdata = '0;
      addrK = '0;
      for (int k = 0; k < FETCH_W; k++) begin
         addrK = {1'b0, raddr} + 65'(k);
         if (addrK < 65'(IMEM_BYTES)) begin
            rdata[8*k +: 8] = r_mem[addrK[AW-1:0]];
         end
      end
   end

endmodule

// File: rtl/y86_fetch_unit.sv
// y86_fetch_unit: Y86-64 fetch stage.
//   Reads up to 10 bytes at PC, splits them into instruction fields and hands
//   one packet per instruction to decode over a valid/ready handshake.
//   Fetching stops after a halt, an invalid icode or an address fault until
//   reset or redirect.
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     imem_we/waddr/wdata program loader byte write port
//     redirect/redirect_pc PC override from a later stage (highest priority)
//     out_ready           decode accepts the packet
//     out_valid           packet valid
//     icode, ifun, rA, rB instruction fields (rA/rB = 4'hF when absent)
//     valC                constant field, 0 when absent
//     valP                PC + instruction length
//     pc_out              PC of the packet
//     stat                1=AOK 2=HLT 3=ADR 4=INS
//     pred_pc             predicted next PC (only with FETCH_PREDICT_EN)
//   Build option FETCH_PREDICT_EN: jXX/call predict taken (next PC = valC)
//   and the pred_pc port exists. Without it the next PC is always valP.
module y86_fetch_unit
   import y86_pkg::*;
#(
   parameter int          IMEM_BYTES = 1024,
   parameter logic [63:0] RESET_PC   = 64'd0,
   parameter int          FETCH_W    = 10
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          imem_we,
   input  logic [$clog2(IMEM_BYTES)-1:0] imem_waddr,
   input  logic [7:0]                    imem_wdata,
   input  logic                          redirect,
   input  logic [63:0]                   redirect_pc,
   input  logic                          out_ready,
   output logic                          out_valid,
   output logic [3:0]                    icode,
   output logic [3:0]                    ifun,
   output logic [3:0]                    rA,
   output logic [3:0]                    rB,
   output logic [63:0]                   valC,
   output logic [63:0]                   valP,
   output logic [63:0]                   pc_out,
   output logic [2:0]                    stat
`ifdef FETCH_PREDICT_EN
   ,
   output logic [63:0]                   pred_pc
`endif
);

   // The window never shrinks below the longest instruction.
   localparam int FW = (FETCH_W < 10) ? 10 : FETCH_W;

   fetchState_t r_state, w_nextState;

   logic [63:0]   r_pc;
   logic          r_valid;
   logic [3:0]    r_icode, r_ifun, r_rA, r_rB;
   logic [63:0]   r_valC, r_valP, r_pcOut;
   logic [2:0]    r_stat;
`ifdef FETCH_PREDICT_EN
   logic [63:0]   r_predPc;
`endif

   logic [8*FW-1:0] w_win;
   logic [3:0]    w_icode, w_ifun, w_rA, w_rB, w_len;
   logic [63:0]   w_valC, w_valP, w_nextPc;
   logic [64:0]   w_endAddr;
   logic          w_hasReg, w_adrFault;
   logic [2:0]    w_stat;
   logic          w_load;

   y86_imem #(
      .IMEM_BYTES (IMEM_BYTES),
      .FETCH_W    (FW)
   ) u_imem (
      .clk   (clk),
      .we    (imem_we),
      .waddr (imem_waddr),
      .wdata (imem_wdata),
      .raddr (r_pc),
      .rdata (w_win)
   );

   // Split the fetch window into fields and work out length, status and the
   // next PC. The end-address check runs in 65 bits so it cannot wrap.
   always_comb begin
      w_icode  = w_win[7:4];
      w_ifun   = w_win[3:0];
      w_hasReg = (w_icode == I_CMOVXX) || (w_icode == I_IRMOVQ) ||
                 (w_icode == I_RMMOVQ) || (w_icode == I_MRMOVQ) ||
                 (w_icode == I_OPQ)    || (w_icode == I_PUSHQ)  ||
                 (w_icode == I_POPQ);
      w_rA     = w_hasReg ? w_win[15:12] : REG_NONE;
      w_rB     = w_hasReg ? w_win[11:8]  : REG_NONE;
      w_valC   = 64'd0;
      if ((w_icode == I_IRMOVQ) || (w_icode == I_RMMOVQ) || (w_icode == I_MRMOVQ)) begin
         w_valC = w_win[79:16];
      end else if ((w_icode == I_JXX) || (w_icode == I_CALL)) begin
         w_valC = w_win[71:8];
      end
      w_len      = instrLen(w_icode);
      w_valP     = r_pc + 64'(w_len);
      w_endAddr  = {1'b0, r_pc} + 65'(w_len) - 65'd1;
      w_adrFault = (w_endAddr >= 65'(IMEM_BYTES));
      if (w_adrFault) begin
         w_stat = S_ADR;
      end else if (!isValidIcode(w_icode)) begin
         w_stat = S_INS;
      end else if (w_icode == I_HALT) begin
         w_stat = S_HLT;
      end else begin
         w_stat = S_AOK;
      end
      w_nextPc = w_valP;
`ifdef FETCH_PREDICT_EN
      if ((w_icode == I_JXX) || (w_icode == I_CALL)) begin
         w_nextPc = w_valC;
      end
`endif
   end

   // A new packet is taken only while running, with the output slot free or
   // being drained, and never in a redirect cycle.
   assign w_load = !redirect && (r_state == ST_RUN) && (!r_valid || out_ready);

   // Fetch status FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state: redirect always restarts fetching; otherwise the status of
   // the packet being loaded decides whether to keep going.
   always_comb begin
      w_nextState = r_state;
      if (redirect) begin
         w_nextState = ST_RUN;
      end else if (w_load) begin
         if ((w_stat == S_ADR) || (w_stat == S_INS)) begin
            w_nextState = ST_ERR;
         end else if (w_stat == S_HLT) begin
            w_nextState = ST_HLT;
         end else begin
            w_nextState = ST_RUN;
         end
      end
   end

   // PC and output packet register. When stopped, a final accept only
   // clears out_valid; the fields keep their last values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc     <= RESET_PC;
         r_valid  <= 1'b0;
         r_icode  <= 4'd0;
         r_ifun   <= 4'd0;
         r_rA     <= 4'd0;
         r_rB     <= 4'd0;
         r_valC   <= 64'd0;
         r_valP   <= 64'd0;
         r_pcOut  <= 64'd0;
         r_stat   <= S_AOK;
`ifdef FETCH_PREDICT_EN
         r_predPc <= 64'd0;
`endif
      end else if (redirect) begin
         r_pc    <= redirect_pc;
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_pc     <= w_nextPc;
         r_valid  <= 1'b1;
         r_icode  <= w_icode;
         r_ifun   <= w_ifun;
         r_rA     <= w_rA;
         r_rB     <= w_rB;
         r_valC   <= w_valC;
         r_valP   <= w_valP;
         r_pcOut  <= r_pc;
         r_stat   <= w_stat;
`ifdef FETCH_PREDICT_EN
         r_predPc <= w_nextPc;
`endif
      end else if (r_valid && out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid = r_valid;
   assign icode     = r_icode;
   assign ifun      = r_ifun;
   assign rA        = r_rA;
   assign rB        = r_rB;
   assign valC      = r_valC;
   assign valP      = r_valP;
   assign pc_out    = r_pcOut;
   assign stat      = r_stat;
`ifdef FETCH_PREDICT_EN
   assign pred_pc   = r_predPc;
`endif

endmodule

// File: tb/tb_y86_fetch_unit.sv
// tb_y86_fetch_unit: directed bench for y86_fetch_unit (IMEM_BYTES=1024).
//   Loads small programs through the loader port, steers the PC with
//   redirect and compares each packet against hand-computed values.
//   Build option FETCH_PREDICT_EN selects the predicted-taken expectations.
module tb_y86_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_we = 1'b0;
   logic [9:0]  imem_waddr = '0;
   logic [7:0]  imem_wdata = '0;
   logic        redirect = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        out_ready = 1'b1;
   logic        out_valid;
   logic [3:0]  icode, ifun, rA, rB;
   logic [63:0] valC, valP, pc_out;
   logic [2:0]  stat;
`ifdef FETCH_PREDICT_EN
   logic [63:0] pred_pc;
`endif

   int checks = 0;
   int errors = 0;

   y86_fetch_unit #(
      .IMEM_BYTES (1024),
      .RESET_PC   (64'd0),
      .FETCH_W    (10)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_we     (imem_we),
      .imem_waddr  (imem_waddr),
      .imem_wdata  (imem_wdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .icode       (icode),
      .ifun        (ifun),
      .rA          (rA),
      .rB          (rB),
      .valC        (valC),
      .valP        (valP),
      .pc_out      (pc_out),
      .stat        (stat)
`ifdef FETCH_PREDICT_EN
      ,
      .pred_pc     (pred_pc)
`endif
   );

   always #5 clk = ~clk;

   // Drive the handshake/redirect inputs across one rising edge, then settle
   // 1 time unit past the edge so outputs are sampled away from it.
   task automatic applyStimulus(input logic rdr, input logic [63:0] rdrPc, input logic ready);
      redirect    = rdr;
      redirect_pc = rdrPc;
      out_ready   = ready;
      @(posedge clk);
      #1;
      redirect    = 1'b0;
   endtask

   task automatic writeByte(input logic [9:0] addr, input logic [7:0] data);
      imem_we    = 1'b1;
      imem_waddr = addr;
      imem_wdata = data;
      @(posedge clk);
      #1;
      imem_we    = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   initial begin
      logic [7:0] prog [11];
      prog = '{8'h30, 8'hF3, 8'hF0, 8'hDE, 8'hBC, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00};

      // Load irmovq + halt while the fetch unit is held in reset.
      rst = 1'b1;
      for (int i = 0; i < 11; i++) writeByte(10'(i), prog[i]);
      checkOutput("rst_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_stat",  64'(stat),      64'd1);
      checkOutput("rst_pc",    pc_out,         64'd0);
      checkOutput("rst_icode", 64'(icode),     64'd0);
      checkOutput("rst_valP",  valP,           64'd0);
      rst = 1'b0;

      // Packet 1: irmovq at 0.
      applyStimulus(1'b0, 64'd0, 1'b1);
      checkOutput("irm_valid", 64'(out_valid), 64'd1);
      checkOutput("irm_icode", 64'(icode),     64'd3);
      checkOutput("irm_rA",    64'(rA),        64'hF);
      checkOutput("irm_rB",    64'(rB),        64'd3);
      checkOutput("irm_valC",  valC,           64'h123456789ABCDEF0);
      checkOutput("irm_valP",  valP,           64'd10);
      checkOutput("irm_stat",  64'(stat),      64'd1);
      // Packet 2: halt at 10.
      applyStimulus(1'b0, 64'd0, 1'b1);
      checkOutput("hlt_stat",  64'(stat),      64'd2);
      checkOutput("hlt_valP",  valP,           64'd11);
      checkOutput("hlt_pc",    pc_out,         64'd10);
      applyStimulus(1'b0, 64'd0, 1'b1);
      checkOutput("hlt_drop",  64'(out_valid), 64'd0);
      applyStimulus(1'b0, 64'd0, 1'b1);
      checkOutput("hlt_stay",  64'(out_valid), 64'd0);

      // Stall program at 0x40: nop; addq %rax,%rcx; rrmovq %rdx,%rbx; nop; halt.
      writeByte(10'h40, 8'h10);
      writeByte(10'h41, 8'h60);
      writeByte(10'h42, 8'h01);
      writeByte(10'h43, 8'h20);
      writeByte(10'h44, 8'h23);
      writeByte(10'h45, 8'h10);
      writeByte(10'h46, 8'h00);
      applyStimulus(1'b1, 64'h40, 1'b1);
      checkOutput("rd40_valid", 64'(out_valid), 64'd0);
      applyStimulus(1'b0, 64'd0, 1'b1);
      checkOutput("nop_pc",    pc_out,     64'h40);
      checkOutput("nop_icode", 64'(icode), 64'd1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 64'd0, 1'b0);
         checkOutput("stall_valid", 64'(out_valid), 64'd1);
         checkOutput("stall_pc",    pc_out,         64'h40);
         checkOutput("stall_valP",  valP,           64'h41);
      end
      applyStimulus(1'b0, 64'd0, 1'b1);
      checkOutput("opq_pc",    pc_out,     64'h41);
      checkOutput("opq_icode", 64'(icode), 64'd6);
      checkOutput("opq_ifun",  64'(ifun),  64'd0);
      checkOutput("opq_rA",    64'(rA),    64'd0);
      checkOutput("opq_rB",    64'(rB),    64'd1);
      checkOutput("opq_valP",  valP,       64'h43);
      applyStimulus(1'b0, 64'd0, 1'b1);
      checkOutput("cmov_pc",   pc_out,     64'h43);
      checkOutput("cmov_rA",   64'(rA),    64'd2);
      checkOutput("cmov_rB",   64'(rB),    64'd3);

      // Redirect in the same cycle as a stall with a valid packet pending.
      applyStimulus(1'b1, 64'h45, 1'b0);
      checkOutput("rdstall_valid", 64'(out_valid), 64'd0);
      applyStimulus(1'b0, 64'd0, 1'b1);
      checkOutput("rdstall_pc",    pc_out,         64'h45);
      checkOutput("rdstall_icode", 64'(icode),     64'd1);
      applyStimulus(1'b0, 64'd0, 1'b1);
      checkOutput("hlt2_stat",     64'(stat),      64'd2);
      checkOutput("hlt2_pc",       pc_out,         64'h46);
      applyStimulus(1'b0, 64'd0, 1'b1);
      checkOutput("hlt2_drop",     64'(out_valid), 64'd0);

      // Invalid icode 0xC0 at PC 4.
      writeByte(10'd4, 8'hC0);
      applyStimulus(1'b1, 64'd4, 1'b1);
      applyStimulus(1'b0, 64'd0, 1'b1);
      checkOutput("ins_valid", 64'(out_valid), 64'd1);
      checkOutput("ins_stat",  64'(stat),      64'd4);
      checkOutput("ins_icode", 64'(icode),     64'hC);
      checkOutput("ins_rA",    64'(rA),        64'hF);
      checkOutput("ins_valP",  valP,           64'd5);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 64'd0, 1'b1);
         checkOutput("ins_stopped", 64'(out_valid), 64'd0);
      end
      applyStimulus(1'b1, 64'd0, 1'b1);
      applyStimulus(1'b0, 64'd0, 1'b1);
      checkOutput("restart_valid", 64'(out_valid), 64'd1);
      checkOutput("restart_pc",    pc_out,         64'd0);
      checkOutput("restart_icode", 64'(icode),     64'd3);

      // irmovq ending exactly on the last byte is fine; the byte after faults.
      writeByte(10'd1014, 8'h30);
      writeByte(10'd1015, 8'hF1);
      for (int i = 0; i < 8; i++) writeByte(10'(1016 + i), 8'(i + 1));
      applyStimulus(1'b1, 64'd1014, 1'b1);
      applyStimulus(1'b0, 64'd0, 1'b1);
      checkOutput("edge_stat", 64'(stat),  64'd1);
      checkOutput("edge_pc",   pc_out,     64'd1014);
      checkOutput("edge_rB",   64'(rB),    64'd1);
      checkOutput("edge_valC", valC,       64'h0807060504030201);
      checkOutput("edge_valP", valP,       64'd1024);
      applyStimulus(1'b0, 64'd0, 1'b1);
      checkOutput("oob_stat",  64'(stat),  64'd3);
      checkOutput("oob_pc",    pc_out,     64'd1024);
      applyStimulus(1'b0, 64'd0, 1'b1);
      checkOutput("oob_drop",  64'(out_valid), 64'd0);

      // rmmovq at IMEM_BYTES-5 runs off the end.
      writeByte(10'd1019, 8'h40);
      writeByte(10'd1020, 8'h12);
      applyStimulus(1'b1, 64'd1019, 1'b1);
      applyStimulus(1'b0, 64'd0, 1'b1);
      checkOutput("adr_stat",  64'(stat),  64'd3);
      checkOutput("adr_icode", 64'(icode), 64'd4);
      checkOutput("adr_rA",    64'(rA),    64'd1);
      checkOutput("adr_rB",    64'(rB),    64'd2);
      checkOutput("adr_valP",  valP,       64'd1029);
      applyStimulus(1'b0, 64'd0, 1'b1);
      checkOutput("adr_stopped", 64'(out_valid), 64'd0);
      applyStimulus(1'b0, 64'd0, 1'b1);
      checkOutput("adr_stopped2", 64'(out_valid), 64'd0);

      // jmp 0x40 at 0x80.
      writeByte(10'h80, 8'h70);
      writeByte(10'h81, 8'h40);
      applyStimulus(1'b1, 64'h80, 1'b1);
      applyStimulus(1'b0, 64'd0, 1'b1);
      checkOutput("jmp_icode", 64'(icode), 64'd7);
      checkOutput("jmp_valC",  valC,       64'h40);
      checkOutput("jmp_valP",  valP,       64'h89);
      checkOutput("jmp_rA",    64'(rA),    64'hF);
`ifdef FETCH_PREDICT_EN
      checkOutput("jmp_pred",  pred_pc,    64'h40);
      applyStimulus(1'b0, 64'd0, 1'b1);
      checkOutput("after_jmp_pc", pc_out,  64'h40);
`else
      applyStimulus(1'b0, 64'd0, 1'b1);
      checkOutput("after_jmp_pc", pc_out,  64'h89);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
